btn_counter: RTL and testbench
==============================

Name: btn_counter

Overview:
- Produces the 8-bit signed two's-complement value that drives the seven-segment driver's `ssd_input`.
- Three raw push-buttons (increment, decrement, clear) are synchronised, debounced and edge-detected.
- The resulting one-cycle press events update a saturating signed counter, clamped to the displayable range -9..99.
- Sits between board buttons and the display driver, in the 125 MHz clock domain.

Parameters:
- DB_CYCLES, 1250000, number of consecutive cycles a synchronised input must differ from its debounced level before the level flips (10 ms at 125 MHz). Must be >= 2.
- COUNT_MIN, -9, lowest count value, signed 8-bit.
- COUNT_MAX, 99, highest count value, signed 8-bit.

Ports:
- clk  input  1  system clock, 125 MHz.
- reset  input  1  asynchronous, active-high reset.
- inc_btn  input  1  raw increment button, asynchronous, may bounce.
- dec_btn  input  1  raw decrement button, asynchronous, may bounce.
- clr_btn  input  1  raw clear button, asynchronous, may bounce.
- count  output  8  current value, signed two's complement; drives `ssd_input`.
- changed  output  1  one-cycle pulse, high in the cycle after `count` takes a new value.

Behaviour:
- Reset: asynchronous, active-high; every register clears while `reset` is high.
  - `count` = 8'h00, `changed` = 0.
  - All synchroniser flops, debounced levels, debounce counters and edge-detect history = 0.
- Synchroniser: two flops per button. The raw input is visible as `sync` after 2 rising edges.
- Debounce (per button):
  - Counter `db_cnt`, width $clog2(DB_CYCLES), and level `db`.
  - Each edge where `sync == db`: `db_cnt` <= 0.
  - Each edge where `sync != db` and `db_cnt < DB_CYCLES-1`: `db_cnt` increments.
  - Each edge where `sync != db` and `db_cnt == DB_CYCLES-1`: `db` <= `sync` and `db_cnt` <= 0.
  - Any glitch shorter than DB_CYCLES cycles leaves `db` unchanged.
- Edge detect:
  - `db_d` is `db` registered.
  - `press = db & ~db_d`: a one-cycle pulse on press only; release generates no event.
- Latency: a clean input rising before edge 1 makes `db` rise at edge DB_CYCLES+2. `press` is high in the following cycle, and `count` updates at edge DB_CYCLES+3.
- Count update, evaluated each edge in this priority order:
  1. `clr_press`: `count` <= 0, regardless of `inc_press`/`dec_press`.
  2. `inc_press` and `dec_press` together: no change.
  3. `inc_press` only: if `count` == COUNT_MAX, hold; else `count` + 1.
  4. `dec_press` only: if `count` == COUNT_MIN, hold; else `count` - 1.
- Arithmetic: signed 8-bit compares, so `count` never leaves [COUNT_MIN, COUNT_MAX].
  - Decrement from 0 yields 8'hFF (-1).
  - -9 is 8'hF7.
- `changed`: registered, high for exactly one cycle after any edge where `count` actually changes value.
  - A saturated hold does not assert it.
  - Clear when `count` is already 0 does not assert it.
- Button held across reset release: `db` restarts at 0, so the held button re-qualifies and produces exactly one press DB_CYCLES+3 edges after release.
- Reset asserted mid-debounce: partial progress is discarded.
- Holding a button produces one event only; there is no auto-repeat.

Decomposition:
- Shared Verilog include file holds:
  - COUNT_MIN and COUNT_MAX defaults, as 8-bit signed localparams common with the display driver's range.
  - The 125 MHz clock-rate constant used to derive DB_CYCLES.
- One sub-module, `btn_debounce`, instantiated three times.
  - Contains the 2-flop synchroniser, debounce counter and rising-edge detector.
  - Parameter DB_CYCLES; ports `clk`, `reset`, `btn_in`, `press`.
- The top level holds only the saturating counter and the `changed` flag.

Test Plan (DB_CYCLES = 4 in all scenarios):
- Reset then idle: `reset` high 3 cycles, release, buttons low 20 cycles -> `count` = 8'h00 and `changed` = 0 throughout.
- Clean press and latency: `inc_btn` rises before edge 1 and is held 20 cycles -> `count` = 1 after edge 7, `changed` high only in the following cycle, no further increments while held; release then one more press -> `count` = 2.
- Bounce rejection: `inc_btn` toggles high/low with 2-cycle pulses for 16 cycles, then stays low -> `count` unchanged at 0 and `changed` never high.
- Saturation: drive `count` to 99 with 99 presses, then 1 more `inc_btn` press -> `count` stays 8'h63, `changed` = 0; clear, then 10 `dec_btn` presses -> `count` = 8'hF7 (-9), and the 10th press gives no change and no `changed`.
- Simultaneous events:
  - From `count` 5, `inc_btn` and `dec_btn` pressed on the same cycle -> `count` stays 5.
  - `inc_btn` and `clr_btn` pressed together -> `count` = 0.
- Reset mid-operation and held button: hold `inc_btn`, assert `reset` at edge 5 (mid-debounce) for 2 cycles with the button still held -> `count` = 0 during reset, then `count` = 1 exactly 7 edges after `reset` falls.

Source files
------------

// File: rtl/btn_counter_pkg.sv
// Shared constants for the button counter: display range and the clock rate
// from which the default debounce window is derived.
package btn_counter_pkg;

   localparam int CLK_HZ          = 125_000_000;
   // 10 ms debounce window at the system clock rate
   localparam int DEF_DB_CYCLES   = CLK_HZ / 100;

   localparam logic signed [7:0] DEF_COUNT_MIN = -8'sd9;
   localparam logic signed [7:0] DEF_COUNT_MAX = 8'sd99;

   localparam int BTN_INC = 0;
   localparam int BTN_DEC = 1;
   localparam int BTN_CLR = 2;
   localparam int NUM_BTN = 3;

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-flop synchroniser, debounce counter and a
// rising-edge detector producing a single-cycle press pulse.
module btn_debounce #(
   parameter int DB_CYCLES = 1250000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic press
);

   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          db_q, db_d;
   logic          db_prev_q, db_prev_d;

   always_comb begin
      sync_d    = {sync_q[0], btn_in};
      db_d      = db_q;
      cnt_d     = '0;
      db_prev_d = db_q;
      // Level flips only after DB_CYCLES consecutive disagreeing samples
      if (sync_q[1] != db_q) begin
         if (cnt_q == CNT_LAST) db_d = sync_q[1];
         else                   cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q    <= '0;
         cnt_q     <= '0;
         db_q      <= 1'b0;
         db_prev_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         db_q      <= db_d;
         db_prev_q <= db_prev_d;
      end
   end

   assign press = db_q & ~db_prev_q;

endmodule

// File: rtl/btn_counter.sv
// Saturating signed counter driven by debounced inc/dec/clear button presses;
// feeds the seven-segment driver input.
module btn_counter
   import btn_counter_pkg::*;
#(
   parameter int                DB_CYCLES = DEF_DB_CYCLES,
   parameter logic signed [7:0] COUNT_MIN = DEF_COUNT_MIN,
   parameter logic signed [7:0] COUNT_MAX = DEF_COUNT_MAX
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc_btn,
   input  logic       dec_btn,
   input  logic       clr_btn,
   output logic [7:0] count,
   output logic       changed
);

   logic [NUM_BTN-1:0] btn_raw;
   logic [NUM_BTN-1:0] press;
   logic               inc_press, dec_press, clr_press;

   logic signed [7:0]  count_q, count_d;
   logic               changed_q, changed_d;

   always_comb begin
      btn_raw          = '0;
      btn_raw[BTN_INC] = inc_btn;
      btn_raw[BTN_DEC] = dec_btn;
      btn_raw[BTN_CLR] = clr_btn;
   end

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db [NUM_BTN-1:0] (
      .clk    (clk),
      .reset  (reset),
      .btn_in (btn_raw),
      .press  (press)
   );

   assign inc_press = press[BTN_INC];
   assign dec_press = press[BTN_DEC];
   assign clr_press = press[BTN_CLR];

   always_comb begin
      count_d = count_q;
      // Clear wins; opposing inc+dec in the same cycle cancel out
      if (clr_press) begin
         count_d = '0;
      end else if (inc_press && !dec_press) begin
         if (count_q < COUNT_MAX) count_d = count_q + 8'sd1;
      end else if (dec_press && !inc_press) begin
         if (count_q > COUNT_MIN) count_d = count_q - 8'sd1;
      end
      changed_d = (count_d != count_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q   <= '0;
         changed_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         changed_q <= changed_d;
      end
   end

   assign count   = count_q;
   assign changed = changed_q;

endmodule

// File: tb/tb_btn_counter.sv
// Scoreboarded bench for btn_counter with a short debounce window: a windowed
// reference model predicts count/changed every cycle; a monitor compares.
module tb_btn_counter;

   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       inc_btn = 1'b0, dec_btn = 1'b0, clr_btn = 1'b0;
   logic [7:0] count;
   logic       changed;

   int total = 0;
   int bad   = 0;

   logic [8:0] sb[$];

   btn_counter #(.DB_CYCLES(DB)) dut (
      .clk     (clk),
      .reset   (reset),
      .inc_btn (inc_btn),
      .dec_btn (dec_btn),
      .clr_btn (clr_btn),
      .count   (count),
      .changed (changed)
   );

   always #5 clk = ~clk;

   // Reference model. hist[b][j] is the raw level sampled j edges ago; a level
   // flips when the DB samples that have made it through the synchroniser
   // all disagree with it. A rise becomes an event applied on the next edge.
   int hist[3][DB+2];
   int m_db[3];
   int pend[3];
   int m_cnt;
   int m_chg;

   always @(posedge clk) begin
      int raw[3];
      int old;
      raw[0] = int'(inc_btn); raw[1] = int'(dec_btn); raw[2] = int'(clr_btn);
      if (reset) begin
         for (int b = 0; b < 3; b++) begin
            for (int j = 0; j < DB + 2; j++) hist[b][j] = 0;
            m_db[b] = 0;
            pend[b] = 0;
         end
         m_cnt = 0;
         m_chg = 0;
      end else begin
         for (int b = 0; b < 3; b++) begin
            for (int j = DB + 1; j > 0; j--) hist[b][j] = hist[b][j-1];
            hist[b][0] = raw[b];
         end
         old = m_cnt;
         if (pend[2] != 0)                    m_cnt = 0;
         else if (pend[0] != 0 && pend[1] == 0) m_cnt = (m_cnt + 1 > 99) ? 99 : m_cnt + 1;
         else if (pend[1] != 0 && pend[0] == 0) m_cnt = (m_cnt - 1 < -9) ? -9 : m_cnt - 1;
         m_chg = (m_cnt != old) ? 1 : 0;
         for (int b = 0; b < 3; b++) begin
            bit all_diff;
            all_diff = 1'b1;
            for (int j = 2; j < DB + 2; j++)
               if (hist[b][j] == m_db[b]) all_diff = 1'b0;
            pend[b] = 0;
            if (all_diff) begin
               m_db[b] = 1 - m_db[b];
               pend[b] = m_db[b];
            end
         end
      end
      sb.push_back({1'(m_chg), 8'(m_cnt)});
   end

   always @(negedge clk) begin
      logic [8:0] e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         total++;
         if (count !== e[7:0] || changed !== e[8]) begin
            bad++;
            $display("FAIL scoreboard t=%0t: got count=%02h changed=%b, want count=%02h changed=%b",
                     $time, count, changed, e[7:0], e[8]);
         end
      end
   end

   task automatic hold(input logic i, input logic d, input logic c, input int n);
      repeat (n) begin
         @(negedge clk); #1;
         inc_btn = i; dec_btn = d; clr_btn = c;
      end
   endtask

   task automatic tap(input logic i, input logic d, input logic c);
      hold(i, d, c, 7);
      hold(1'b0, 1'b0, 1'b0, 7);
   endtask

   task automatic chk(input string nm, input logic [7:0] exp);
      @(negedge clk); #2;
      total++;
      if (count !== exp) begin
         bad++;
         $display("FAIL %s: got count=%02h, want %02h", nm, count, exp);
      end
   endtask

   initial begin
      // reset then idle
      repeat (3) @(negedge clk);
      #1 reset = 1'b0;
      hold(1'b0, 1'b0, 1'b0, 20);
      chk("idle", 8'h00);

      // bounce: 2-cycle pulses never qualify
      repeat (4) begin
         hold(1'b1, 1'b0, 1'b0, 2);
         hold(1'b0, 1'b0, 1'b0, 2);
      end
      hold(1'b0, 1'b0, 1'b0, 10);
      chk("bounce", 8'h00);

      // clean press held, then a second press
      hold(1'b1, 1'b0, 1'b0, 20);
      chk("held_press", 8'h01);
      hold(1'b0, 1'b0, 1'b0, 10);
      tap(1'b1, 1'b0, 1'b0);
      chk("second_press", 8'h02);

      // saturation at the top, then at the bottom
      tap(1'b0, 1'b0, 1'b1);
      repeat (99) tap(1'b1, 1'b0, 1'b0);
      chk("reach_max", 8'h63);
      tap(1'b1, 1'b0, 1'b0);
      chk("hold_max", 8'h63);
      tap(1'b0, 1'b0, 1'b1);
      chk("clear", 8'h00);
      tap(1'b0, 1'b1, 1'b0);
      chk("dec_from_0", 8'hFF);
      repeat (9) tap(1'b0, 1'b1, 1'b0);
      chk("hold_min", 8'hF7);

      // simultaneous presses
      tap(1'b0, 1'b0, 1'b1);
      repeat (5) tap(1'b1, 1'b0, 1'b0);
      tap(1'b1, 1'b1, 1'b0);
      chk("inc_dec_cancel", 8'h05);
      tap(1'b1, 1'b0, 1'b1);
      chk("inc_clr", 8'h00);

      // reset mid-debounce with the button held through it
      hold(1'b1, 1'b0, 1'b0, 4);
      @(negedge clk); #1 reset = 1'b1;
      chk("in_reset", 8'h00);
      @(negedge clk); #1 reset = 1'b0;
      hold(1'b1, 1'b0, 1'b0, 12);
      chk("held_through_reset", 8'h01);
      hold(1'b0, 1'b0, 1'b0, 8);

      // randomized run-length stimulus with occasional resets
      repeat (600) begin
         int n;
         n = $urandom_range(1, 9);
         if ($urandom_range(0, 99) == 0) begin
            @(negedge clk); #1 reset = 1'b1;
            @(negedge clk); #1 reset = 1'b0;
         end
         hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 9) == 0), n);
      end
      hold(1'b0, 1'b0, 1'b0, 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
